// File: rtl/regfile_pkg.sv
// Shared types and helpers for the LVT-based multiport register file.
package regfile_pkg;

  localparam int MAX_WRITE_PORTS = 8;

  typedef enum logic {INIT, RUN} regfile_state_e;

  function automatic int lvt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/regfile_lvt_multiport_if.sv
// Request/response bundle between the register-read stage and the multiport register file.
interface regfile_lvt_multiport_if #(
  parameter int DATA_WIDTH  = 64,
  parameter int ADDR_WIDTH  = 8,
  parameter int WRITE_PORTS = 4,
  parameter int READ_PORTS  = 8
);
  logic [WRITE_PORTS-1:0]            wr_en;
  logic [ADDR_WIDTH*WRITE_PORTS-1:0] wr_addr;
  logic [DATA_WIDTH*WRITE_PORTS-1:0] wr_data;
  logic [READ_PORTS-1:0]             rd_en;
  logic [ADDR_WIDTH*READ_PORTS-1:0]  rd_addr;
  logic [DATA_WIDTH*READ_PORTS-1:0]  rd_data;
  logic [READ_PORTS-1:0]             rd_valid;
  logic                              init_busy;
  logic                              wr_collision;

  modport master (
    output wr_en, wr_addr, wr_data, rd_en, rd_addr,
    input  rd_data, rd_valid, init_busy, wr_collision
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
    output rd_data, rd_valid, init_busy, wr_collision
  );
endinterface

// File: rtl/regfile_lvt_multiport_sdp_bram.sv
// Simple dual-port bank: one write port, one registered read-first read port, clk_en-gated.
module sdp_bram #(
  parameter int DATA_WIDTH = 64,
  parameter int REG_COUNT  = 256,
  parameter int ADDR_WIDTH = $clog2(REG_COUNT)
) (
  input  logic                  clk,
  input  logic                  clk_en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [REG_COUNT];

  always_ff @(posedge clk) begin
    if (clk_en) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/regfile_lvt_multiport.sv
// W-write / R-read register file from W*R 1W1R banks steered by a flop Live Value Table.
// Optional macro REGFILE_BYPASS_EN adds same-cycle write-to-read forwarding.
module regfile_lvt_multiport
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int REG_COUNT   = 256,
  parameter int ADDR_WIDTH  = $clog2(REG_COUNT),
  parameter int WRITE_PORTS = 4,
  parameter int READ_PORTS  = 8
) (
  input logic                     clk,
  input logic                     sync_rst,
  input logic                     clk_en,
  regfile_lvt_multiport_if.slave  bus
);

  localparam int LVT_W = lvt_width(WRITE_PORTS);

  regfile_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    init_active;
  logic                    run;
  logic [WRITE_PORTS-1:0]  wr_act;

  logic [DATA_WIDTH-1:0]   bank_q [WRITE_PORTS][READ_PORTS];
  logic [LVT_W-1:0]        lvt [REG_COUNT];
  logic [LVT_W-1:0]        sel_p1 [READ_PORTS];
  logic [READ_PORTS-1:0]   vld_p1;
  logic [DATA_WIDTH-1:0]   mux_p1 [READ_PORTS];
  logic [DATA_WIDTH-1:0]   hold_q [READ_PORTS];
  logic                    coll_p0;
  logic                    coll_p1;

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else if (clk_en) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == ADDR_WIDTH'(REG_COUNT - 1)) state_d = RUN;
      end
      RUN: state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  assign init_active = (state_q == INIT);
  assign run         = (state_q == RUN);
  assign wr_act      = run ? bus.wr_en : '0;

  // p0: bank write/read issue; the zero-fill sweep takes over every write port while INIT
  for (genvar i = 0; i < WRITE_PORTS; i++) begin : g_wr
    logic                  we;
    logic [ADDR_WIDTH-1:0] wa;
    logic [DATA_WIDTH-1:0] wd;

    assign we = init_active | wr_act[i];
    assign wa = init_active ? cnt_q : bus.wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign wd = init_active ? '0    : bus.wr_data[i*DATA_WIDTH +: DATA_WIDTH];

    for (genvar r = 0; r < READ_PORTS; r++) begin : g_rd
      sdp_bram #(
        .DATA_WIDTH (DATA_WIDTH),
        .REG_COUNT  (REG_COUNT),
        .ADDR_WIDTH (ADDR_WIDTH)
      ) u_bank (
        .clk    (clk),
        .clk_en (clk_en),
        .we     (we),
        .waddr  (wa),
        .wdata  (wd),
        .re     (bus.rd_en[r]),
        .raddr  (bus.rd_addr[r*ADDR_WIDTH +: ADDR_WIDTH]),
        .rdata  (bank_q[i][r])
      );
    end
  end

  // Later ports overwrite earlier ones in the loop, so the highest index owns the entry
  always_ff @(posedge clk) begin
    if (clk_en) begin
      if (init_active) begin
        lvt[cnt_q] <= '0;
      end else begin
        for (int i = 0; i < WRITE_PORTS; i++) begin
          if (bus.wr_en[i]) lvt[bus.wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH]] <= LVT_W'(i);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clk_en) begin
      for (int r = 0; r < READ_PORTS; r++) begin
        if (bus.rd_en[r]) sel_p1[r] <= lvt[bus.rd_addr[r*ADDR_WIDTH +: ADDR_WIDTH]];
      end
    end
  end

  always_comb begin
    coll_p0 = 1'b0;
    for (int i = 0; i < WRITE_PORTS; i++) begin
      for (int j = i + 1; j < WRITE_PORTS; j++) begin
        if (wr_act[i] && wr_act[j] &&
            bus.wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH] == bus.wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH])
          coll_p0 = 1'b1;
      end
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic [READ_PORTS-1:0] fwd_hit_p0, fwd_hit_p1;
  logic [DATA_WIDTH-1:0] fwd_data_p0 [READ_PORTS];
  logic [DATA_WIDTH-1:0] fwd_data_p1 [READ_PORTS];

  always_comb begin
    fwd_hit_p0 = '0;
    for (int r = 0; r < READ_PORTS; r++) begin
      fwd_data_p0[r] = '0;
      for (int i = 0; i < WRITE_PORTS; i++) begin
        if (wr_act[i] && bus.wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH] ==
                         bus.rd_addr[r*ADDR_WIDTH +: ADDR_WIDTH]) begin
          fwd_hit_p0[r]  = 1'b1;
          fwd_data_p0[r] = bus.wr_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clk_en) begin
      for (int r = 0; r < READ_PORTS; r++) begin
        if (bus.rd_en[r]) begin
          fwd_hit_p1[r]  <= fwd_hit_p0[r];
          fwd_data_p1[r] <= fwd_data_p0[r];
        end
      end
    end
  end
`endif

  // p1: bank outputs steered by the latched LVT entry, forward path last
  always_comb begin
    for (int r = 0; r < READ_PORTS; r++) begin
      mux_p1[r] = bank_q[0][r];
      for (int i = 1; i < WRITE_PORTS; i++) begin
        if (sel_p1[r] == LVT_W'(i)) mux_p1[r] = bank_q[i][r];
      end
`ifdef REGFILE_BYPASS_EN
      if (fwd_hit_p1[r]) mux_p1[r] = fwd_data_p1[r];
`endif
    end
  end

  // hold_q remembers the last delivered word so rd_data stays put while rd_valid is low
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      vld_p1  <= '0;
      coll_p1 <= 1'b0;
      for (int r = 0; r < READ_PORTS; r++) hold_q[r] <= '0;
    end else if (clk_en) begin
      vld_p1  <= run ? bus.rd_en : '0;
      coll_p1 <= coll_p0;
      for (int r = 0; r < READ_PORTS; r++) begin
        if (vld_p1[r]) hold_q[r] <= mux_p1[r];
      end
    end
  end

  for (genvar r = 0; r < READ_PORTS; r++) begin : g_out
    assign bus.rd_data[r*DATA_WIDTH +: DATA_WIDTH] = vld_p1[r] ? mux_p1[r] : hold_q[r];
  end

  assign bus.rd_valid     = vld_p1;
  assign bus.init_busy    = init_active;
  assign bus.wr_collision = coll_p1;

endmodule

// File: tb/tb_regfile_lvt_multiport.sv
// Randomized bench for regfile_lvt_multiport against a single-array behavioural register-file model.
module tb_regfile_lvt_multiport;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic sync_rst;
  logic clk_en;

  regfile_lvt_multiport_if #(
    .DATA_WIDTH(16), .ADDR_WIDTH(4), .WRITE_PORTS(2), .READ_PORTS(2)
  ) bus ();

  regfile_lvt_multiport #(
    .DATA_WIDTH(16), .REG_COUNT(16), .ADDR_WIDTH(4), .WRITE_PORTS(2), .READ_PORTS(2)
  ) dut (
    .clk      (clk),
    .sync_rst (sync_rst),
    .clk_en   (clk_en),
    .bus      (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: one logical 16-entry register file plus the outputs expected after the next edge
  logic [15:0] m_mem [16];
  int          m_left = 0;
  logic        exp_busy = 1'b1;
  logic        exp_coll = 1'b0;
  logic [1:0]  exp_vld  = 2'b00;
  logic [15:0] exp_dat [2] = '{16'h0, 16'h0};
  bit          chk_on = 1'b0;

  int          lit_kind = 0;
  logic [15:0] lit_exp  = '0;
  string       lit_name = "";

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (chk_on) begin
      chk("init_busy",    {15'd0, bus.init_busy},    {15'd0, exp_busy});
      chk("wr_collision", {15'd0, bus.wr_collision}, {15'd0, exp_coll});
      chk("rd_valid0",    {15'd0, bus.rd_valid[0]},  {15'd0, exp_vld[0]});
      chk("rd_valid1",    {15'd0, bus.rd_valid[1]},  {15'd0, exp_vld[1]});
      chk("rd_data0",     bus.rd_data[15:0],         exp_dat[0]);
      chk("rd_data1",     bus.rd_data[31:16],        exp_dat[1]);
      case (lit_kind)
        1: chk(lit_name, {15'd0, bus.init_busy},    lit_exp);
        2: chk(lit_name, {15'd0, bus.wr_collision}, lit_exp);
        3: chk(lit_name, bus.rd_data[15:0],         lit_exp);
        4: chk(lit_name, bus.rd_data[31:16],        lit_exp);
        5: chk(lit_name, {15'd0, bus.rd_valid[0]},  lit_exp);
        6: chk(lit_name, {15'd0, bus.rd_valid[1]},  lit_exp);
        default: ;
      endcase
    end
  end

  task automatic cyc(input bit rst, input bit en,
                     input logic [1:0] we, input logic [3:0] wa0, input logic [3:0] wa1,
                     input logic [15:0] wd0, input logic [15:0] wd1,
                     input logic [1:0] re, input logic [3:0] ra0, input logic [3:0] ra1);
    logic [3:0]  wa [2];
    logic [3:0]  ra [2];
    logic [15:0] wd [2];
    logic [15:0] v;
    @(negedge clk);
    sync_rst     = rst;
    clk_en       = en;
    bus.wr_en    = we;
    bus.wr_addr  = {wa1, wa0};
    bus.wr_data  = {wd1, wd0};
    bus.rd_en    = re;
    bus.rd_addr  = {ra1, ra0};
    lit_kind     = 0;
    wa[0] = wa0; wa[1] = wa1; ra[0] = ra0; ra[1] = ra1; wd[0] = wd0; wd[1] = wd1;
    if (rst) begin
      foreach (m_mem[a]) m_mem[a] = 16'h0;
      m_left   = 16;
      exp_busy = 1'b1;
      exp_coll = 1'b0;
      exp_vld  = 2'b00;
      exp_dat[0] = 16'h0;
      exp_dat[1] = 16'h0;
      chk_on   = 1'b1;
    end else if (!en) begin
      // everything observable holds
    end else if (m_left > 0) begin
      m_left--;
      exp_busy = (m_left > 0);
      exp_vld  = 2'b00;
      exp_coll = 1'b0;
    end else begin
      exp_coll = we[0] && we[1] && (wa0 == wa1);
      for (int r = 0; r < 2; r++) begin
        if (re[r]) begin
          v = m_mem[ra[r]];
`ifdef REGFILE_BYPASS_EN
          for (int i = 0; i < 2; i++) if (we[i] && wa[i] == ra[r]) v = wd[i];
`endif
          exp_dat[r] = v;
          exp_vld[r] = 1'b1;
        end else begin
          exp_vld[r] = 1'b0;
        end
      end
      for (int i = 0; i < 2; i++) if (we[i]) m_mem[wa[i]] = wd[i];
    end
  endtask

  task automatic lit(input int kind, input logic [15:0] val, input string name);
    lit_kind = kind;
    lit_exp  = val;
    lit_name = name;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(0, 1, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0);
  endtask

  initial begin
    sync_rst    = 1'b0;
    clk_en      = 1'b1;
    bus.wr_en   = '0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.rd_en   = '0;
    bus.rd_addr = '0;

    // Reset and zero-fill: busy for exactly 16 enabled cycles
    cyc(1, 1, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0);
    lit(1, 16'd1, "busy_after_reset");
    for (int k = 1; k <= 16; k++) begin
      cyc(0, 1, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0);
      if (k == 15) lit(1, 16'd1, "busy_cycle15");
      if (k == 16) lit(1, 16'd0, "busy_cleared");
    end
    for (int a = 0; a < 16; a++) begin
      cyc(0, 1, 2'b00, 0, 0, 0, 0, 2'b11, 4'(a), 4'(15 - a));
      if (a == 0) lit(5, 16'd1, "first_read_valid");
      if (a == 5) lit(3, 16'h0000, "zero_after_init");
    end

    // LVT follows the most recent writer
    cyc(0, 1, 2'b01, 3, 0, 16'h1111, 0, 2'b00, 0, 0);
    cyc(0, 1, 2'b10, 0, 3, 0, 16'h2222, 2'b00, 0, 0);
    cyc(0, 1, 2'b00, 0, 0, 0, 0, 2'b11, 3, 3);
    lit(3, 16'h2222, "p1_write_wins_port0");
    idle(1);
    lit(4, 16'h2222, "p1_write_wins_port1");
    cyc(0, 1, 2'b01, 3, 0, 16'h3333, 0, 2'b00, 0, 0);
    cyc(0, 1, 2'b00, 0, 0, 0, 0, 2'b01, 3, 0);
    lit(3, 16'h3333, "later_p0_write");

    // Same-address collision
    cyc(0, 1, 2'b11, 5, 5, 16'hAAAA, 16'hBBBB, 2'b00, 0, 0);
    lit(2, 16'd1, "collision_set");
    cyc(0, 1, 2'b00, 0, 0, 0, 0, 2'b01, 5, 0);
    lit(2, 16'd0, "collision_cleared");
    idle(1);
    lit(3, 16'hBBBB, "collision_winner");

    // Same-cycle write and read
    cyc(0, 1, 2'b01, 7, 0, 16'h5555, 0, 2'b01, 7, 0);
`ifdef REGFILE_BYPASS_EN
    lit(3, 16'h5555, "same_cycle_forward");
`else
    lit(3, 16'h0000, "same_cycle_read_first");
`endif
    cyc(0, 1, 2'b00, 0, 0, 0, 0, 2'b01, 7, 0);
    lit(3, 16'h5555, "after_same_cycle_write");

    // clk_en low mid-read with writes pending
    cyc(0, 1, 2'b00, 0, 0, 0, 0, 2'b11, 3, 5);
    lit(4, 16'hBBBB, "read_before_freeze");
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 2'b11, 9, 10, 16'h9999, 16'hA0A0, 2'b11, 9, 10);
      if (k == 2) lit(3, 16'h3333, "hold_while_frozen");
    end
    cyc(0, 1, 2'b00, 0, 0, 0, 0, 2'b11, 9, 10);
    lit(3, 16'h0000, "frozen_write_dropped");

    // Writes ignored during INIT, reset mid-sweep, freeze inside INIT
    cyc(1, 1, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0);
    for (int k = 0; k < 8; k++) cyc(0, 1, 2'b11, 2, 2, 16'h7777, 16'h7777, 2'b11, 2, 2);
    cyc(1, 1, 2'b01, 2, 0, 16'h7777, 0, 2'b00, 0, 0);
    cyc(0, 1, 2'b01, 2, 0, 16'h7777, 0, 2'b00, 0, 0);
    for (int k = 0; k < 3; k++) cyc(0, 0, 2'b01, 2, 0, 16'h7777, 0, 2'b00, 0, 0);
    for (int k = 2; k <= 16; k++) begin
      cyc(0, 1, 2'b01, 2, 0, 16'h7777, 0, 2'b00, 0, 0);
      if (k == 15) lit(1, 16'd1, "busy_after_restart15");
      if (k == 16) lit(1, 16'd0, "busy_after_restart16");
    end
    cyc(0, 1, 2'b00, 0, 0, 0, 0, 2'b10, 0, 2);
    lit(6, 16'd1, "post_restart_valid");
    idle(1);
    lit(4, 16'h0000, "init_write_ignored");

    // Randomized traffic
    for (int k = 0; k < 800; k++) begin
      cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 9) != 0),
          2'($urandom_range(0, 3)), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
          16'($urandom), 16'($urandom),
          2'($urandom_range(0, 3)), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)));
    end
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
